// File: rtl/icache_fetch_pkg.sv
// Shared widths, geometry and FSM encodings for the direct-mapped instruction cache.
package icache_fetch_pkg;
  localparam int unsigned InstAddrBus   = 32;
  localparam int unsigned InstBus       = 32;
  localparam int unsigned ICacheIdxBits = 6;
  localparam int unsigned ICacheTagBits = InstAddrBus - ICacheIdxBits - 2;
  localparam int unsigned ICacheEntries = 1 << ICacheIdxBits;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;
endpackage

// File: rtl/icache_fetch_if.sv
// Instruction-fetch link between the cache (master) and mem_control (slave).
interface icache_fetch_if;
  import icache_fetch_pkg::*;

  logic [InstAddrBus-1:0] mem_inst_addr_o;
  logic                   mem_hold_o;
  logic                   mem_inst_available_i;
  logic [InstBus-1:0]     mem_inst_i;
  logic [InstAddrBus-1:0] mem_inst_addr_i;

  modport master (
    output mem_inst_addr_o, mem_hold_o,
    input  mem_inst_available_i, mem_inst_i, mem_inst_addr_i
  );

  modport slave (
    input  mem_inst_addr_o, mem_hold_o,
    output mem_inst_available_i, mem_inst_i, mem_inst_addr_i
  );
endinterface

// File: rtl/icache_mem.sv
// Valid/tag/data arrays: combinational read by index, synchronous single write port.
module icache_mem
  import icache_fetch_pkg::*;
#(
  parameter int unsigned IDX_BITS = ICacheIdxBits,
  parameter int unsigned TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [InstBus-1:0]  rd_data_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [InstBus-1:0]  wr_data_i
);
  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [InstBus-1:0]  data_q [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data carry no reset so they can map onto block RAM; valid gates them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache between pc_reg/IF and mem_control; holds mem_control off unless a miss is pending.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int unsigned IDX_BITS = ICacheIdxBits,
  parameter int unsigned TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   pc_valid_i,
  input  logic                   if_stall_i,
  input  logic                   branch_flush_i,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_pc_o,
  output logic                   inst_valid_o,
  output logic                   stall_req_o,
  icache_fetch_if.master         mem_if
);
  logic [0:0]             state_q, state_d;
  logic [InstAddrBus-1:0] miss_addr_q, miss_addr_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic [InstAddrBus-1:0] inst_pc_q, inst_pc_d;
  logic                   inst_valid_q, inst_valid_d;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [InstBus-1:0]  rd_data;
  logic                hit, lookup, fill;

  icache_mem #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_mem (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pc_i[IDX_BITS+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill),
    .wr_idx_i   (miss_addr_q[IDX_BITS+1:2]),
    .wr_tag_i   (miss_addr_q[31:IDX_BITS+2]),
    .wr_data_i  (mem_if.mem_inst_i)
  );

  assign hit    = rd_valid && (rd_tag == pc_i[31:IDX_BITS+2]);
  assign lookup = (state_q == ST_IDLE) && pc_valid_i && !if_stall_i && !branch_flush_i;
  // A matching return is written even under flush or stall; only presentation is suppressed.
  assign fill   = (state_q == ST_MISS) && mem_if.mem_inst_available_i &&
                  (mem_if.mem_inst_addr_i == miss_addr_q);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (branch_flush_i) begin
      state_d      = ST_IDLE;
      inst_valid_d = 1'b0;
    end else if (state_q == ST_MISS) begin
      if (fill) begin
        state_d = ST_IDLE;
        if (if_stall_i) begin
          inst_valid_d = 1'b0;
        end else begin
          inst_d       = mem_if.mem_inst_i;
          inst_pc_d    = miss_addr_q;
          inst_valid_d = 1'b1;
        end
      end
    end else if (!if_stall_i) begin
      if (!pc_valid_i) begin
        inst_valid_d = 1'b0;
      end else if (hit) begin
        inst_d       = rd_data;
        inst_pc_d    = pc_i;
        inst_valid_d = 1'b1;
      end else begin
        miss_addr_d  = pc_i;
        state_d      = ST_MISS;
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_o                 = inst_q;
  assign inst_pc_o              = inst_pc_q;
  assign inst_valid_o           = inst_valid_q;
  assign stall_req_o            = !rst && ((state_q == ST_MISS) || (lookup && !hit));
  assign mem_if.mem_hold_o      = (state_q != ST_MISS);
  assign mem_if.mem_inst_addr_o = miss_addr_q;
endmodule
